spec_vram_arbiter: RTL and testbench

//  Shared-SRAM arbiter/fetcher directly upstream of the TV video encoder. It watches the

---
 rtl/spec_vram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_spec_vram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_vram_arbiter.sv
// Single-port SRAM arbiter feeding the TV encoder: fetches pixel + colour for the current
// vram address into a held vdata word and interleaves CPU reads/writes (video first).
`timescale 1ns/1ps
module spec_vram_arbiter #(
  parameter int         ACC_CYC   = 2,
  parameter logic [1:0] SCR_BASE  = 2'b10,
  parameter logic       COL_PLANE = 1'b1
) (
  input  logic        clkVid,
  input  logic        reset_n,
  input  logic [13:0] vram,
  output logic [15:0] vdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        col_wr,
  output logic [16:0] sram_addr,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  // Worst-case video latency is 4*ACC_CYC+1 clocks and must fit inside the 16-clock vram hold.
  if (ACC_CYC < 2 || ACC_CYC > 3) begin : g_bad_acc_cyc
    $error("spec_vram_arbiter: ACC_CYC must be 2 or 3");
  end

  typedef enum logic [2:0] {S_IDLE, S_VPIX, S_VCOL, S_CRD, S_CWR, S_CWCOL} state_e;

  localparam logic [1:0] LAST_CNT = 2'(ACC_CYC - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [13:0] vaddr_q;
  logic        vid_pend_q, vid_pend_d;
  logic        stale_q, stale_d;
  logic [7:0]  pix_tmp_q, pix_tmp_d;
  logic [15:0] vdata_q, vdata_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [2:0]  col_q, col_d;

  logic last, vram_chg, scr_col_hit, fetch_ok;
  state_e cpu_next;

  assign last        = (state_q != S_IDLE) && (cnt_q == LAST_CNT);
  assign vram_chg    = (vram != vaddr_q);
  assign scr_col_hit = (cpu_addr[15:14] == SCR_BASE) && (cpu_addr[13:12] != 2'b00);
  // A fetch only lands in vdata if vram held still for its whole duration.
  assign fetch_ok    = (state_q == S_VCOL) && last && !stale_q && !vram_chg;
  // Finished CPU cycles hand straight over to a waiting video fetch.
  assign cpu_next    = vid_pend_q ? S_VPIX : S_IDLE;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clkVid or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? 2'd0 : cnt_q + 2'd1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 2'd0;
        if (vid_pend_q)   state_d = S_VPIX;
        else if (cpu_req) state_d = cpu_we ? S_CWR : S_CRD;
      end
      S_VPIX:  if (last) state_d = S_VCOL;
      S_VCOL:  if (last) state_d = S_IDLE;
      S_CRD:   if (last) state_d = cpu_next;
      S_CWR:   if (last) state_d = scr_col_hit ? S_CWCOL : cpu_next;
      S_CWCOL: if (last) state_d = cpu_next;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sram_addr = 17'd0;
    sram_dout = 8'd0;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    unique case (state_q)
      S_VPIX: begin
        sram_addr = {1'b0, SCR_BASE, vram};
        sram_oe_n = 1'b0;
      end
      S_VCOL: begin
        sram_addr = {COL_PLANE, SCR_BASE, vram};
        sram_oe_n = 1'b0;
      end
      S_CRD: begin
        sram_addr = {1'b0, cpu_addr};
        sram_oe_n = 1'b0;
      end
      S_CWR: begin
        sram_addr = {1'b0, cpu_addr};
        sram_dout = cpu_din;
        sram_we_n = !last;
      end
      S_CWCOL: begin
        sram_addr = {COL_PLANE, cpu_addr};
        sram_dout = {5'b0, col_q};
        sram_we_n = !last;
      end
      default: ;
    endcase
  end

  always_comb begin
    vid_pend_d = vram_chg ? 1'b1 : (fetch_ok ? 1'b0 : vid_pend_q);
    stale_d    = stale_q;
    if (state_d == S_VPIX && state_q != S_VPIX)                  stale_d = 1'b0;
    else if ((state_q == S_VPIX || state_q == S_VCOL) && vram_chg) stale_d = 1'b1;
    pix_tmp_d  = (state_q == S_VPIX && last) ? sram_din : pix_tmp_q;
    vdata_d    = fetch_ok ? {5'b0, sram_din[2:0], pix_tmp_q} : vdata_q;
    cpu_dout_d = (state_q == S_CRD && last) ? sram_din : cpu_dout_q;
    cpu_ack_d  = last && (state_q == S_CRD || state_q == S_CWCOL ||
                          (state_q == S_CWR && !scr_col_hit));
    col_d      = col_wr ? cpu_din[2:0] : col_q;
  end

  always_ff @(posedge clkVid or negedge reset_n) begin
    if (!reset_n) begin
      vaddr_q    <= 14'd0;
      vid_pend_q <= 1'b1;
      stale_q    <= 1'b0;
      pix_tmp_q  <= 8'd0;
      vdata_q    <= 16'd0;
      cpu_dout_q <= 8'd0;
      cpu_ack_q  <= 1'b0;
      col_q      <= 3'b111;
    end else begin
      vaddr_q    <= vram;
      vid_pend_q <= vid_pend_d;
      stale_q    <= stale_d;
      pix_tmp_q  <= pix_tmp_d;
      vdata_q    <= vdata_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_ack_q  <= cpu_ack_d;
      col_q      <= col_d;
    end
  end

  assign vdata    = vdata_q;
  assign cpu_dout = cpu_dout_q;
  assign cpu_ack  = cpu_ack_q;

endmodule

// File: tb/tb_spec_vram_arbiter.sv
// Scoreboard bench for spec_vram_arbiter: a behavioural SRAM plus a reference memory image
// predict every CPU completion and every vdata update; monitors compare as they appear.
`timescale 1ns/1ps
module tb_spec_vram_arbiter;
  localparam int ACC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] vram;
  logic [15:0] vdata;
  logic        cpu_req, cpu_we, cpu_ack, col_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout, sram_dout, sram_din;
  logic [16:0] sram_addr;
  logic        sram_oe_n, sram_we_n;

  always #5 clk = ~clk;

  spec_vram_arbiter #(.ACC_CYC(ACC)) dut (
    .clkVid(clk), .reset_n(rst_n), .vram(vram), .vdata(vdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .col_wr(col_wr),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  logic [7:0] sram_mem [0:131071];
  logic [7:0] ref_mem  [0:131071];
  int we_cnt = 0;

  assign sram_din = sram_mem[sram_addr];
  always @(negedge clk) if (!sram_we_n) begin
    sram_mem[sram_addr] = sram_dout;
    we_cnt++;
  end

  int compared = 0, mismatched = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    compared++;
    mismatched++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  typedef struct {
    bit         rd;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          col;
    logic [2:0]  colv;
  } cpu_exp_t;

  cpu_exp_t    cpu_q[$];
  logic [15:0] vid_q[$];
  logic [15:0] last_exp;
  logic [2:0]  latch_m;
  int ack_cnt = 0, exp_acks = 0, vid_seen = 0, exp_we = 0;
  int ack_n, vid_n;

  function automatic logic [15:0] exp_vdata(logic [13:0] v);
    return {5'b0, ref_mem[{1'b1, 2'b10, v}][2:0], ref_mem[{1'b0, 2'b10, v}]};
  endfunction

  // Monitors: CPU completions and every vdata change are checked against the queues.
  logic [15:0] prev_vdata;
  always @(negedge clk) begin : mon
    cpu_exp_t e;
    if (!rst_n) prev_vdata = vdata;
    else begin
      if (cpu_ack) begin
        ack_cnt++;
        if (cpu_q.size() == 0) fail_now("unexpected_cpu_ack");
        else begin
          e = cpu_q.pop_front();
          if (e.rd) check("cpu_read_data", {24'd0, cpu_dout}, {24'd0, e.data});
          else begin
            check("sram_pixel_plane", {24'd0, sram_mem[{1'b0, e.addr}]}, {24'd0, e.data});
            if (e.col)
              check("sram_colour_plane", {24'd0, sram_mem[{1'b1, e.addr}]}, {29'd0, e.colv});
          end
        end
      end
      if (vdata !== prev_vdata) begin
        vid_seen++;
        if (vid_q.size() == 0) check("unexpected_vdata", {16'd0, vdata}, {16'd0, prev_vdata});
        else check("vdata", {16'd0, vdata}, {16'd0, vid_q.pop_front()});
        prev_vdata = vdata;
      end
    end
  end

  task automatic start_cpu(bit we, logic [15:0] a, logic [7:0] d, bit track);
    cpu_exp_t e;
    e.rd = !we; e.addr = a; e.col = 1'b0; e.colv = latch_m; e.data = ref_mem[{1'b0, a}];
    if (we) begin
      e.data = d;
      ref_mem[{1'b0, a}] = d;
      exp_we++;
      if (a[15:14] == 2'b10 && a[13:12] != 2'b00) begin
        e.col = 1'b1;
        ref_mem[{1'b1, a}] = {5'b0, latch_m};
        exp_we++;
      end
    end
    if (track) begin
      cpu_q.push_back(e);
      exp_acks++;
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ack && n < 40);
    if (!cpu_ack) fail_now("cpu_ack_timeout");
    cpu_req = 1'b0;
  endtask

  task automatic set_vram(logic [13:0] v, bit expect_update);
    vram = v;
    if (expect_update) begin
      last_exp = exp_vdata(v);
      vid_q.push_back(last_exp);
    end
  endtask

  task automatic wait_vid(output int n);
    int base;
    base = vid_seen;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (vid_seen == base && n < 40);
    if (vid_seen == base) fail_now("vdata_update_timeout");
  endtask

  function automatic logic [13:0] pick_vram(logic [15:0] avoid);
    logic [13:0] v;
    do v = 14'($urandom_range(0, 4095));
    while (exp_vdata(v) == last_exp || exp_vdata(v) == avoid);
    return v;
  endfunction

  // CPU writes stay clear of the video test window (0x8000-0x8FFF) and of 0x9029.
  function automatic logic [15:0] pick_wr_addr();
    logic [15:0] a;
    do a = 16'($urandom);
    while (a[15:12] == 4'h8 || a == 16'h9029);
    return a;
  endfunction

  task automatic pulse_col(logic [7:0] d);
    col_wr = 1'b1; cpu_din = d;
    @(negedge clk);
    col_wr = 1'b0;
    latch_m = d[2:0];
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int base_we, r;
    logic [13:0] va, vb;
    for (int i = 0; i < 131072; i++) begin
      sram_mem[i] = 8'($urandom);
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[17'h09029] = 8'h5A;
    ref_mem[17'h09029]  = 8'h5A;
    rst_n = 1'b0; vram = 14'h1029; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0;
    cpu_din = 8'd0; col_wr = 1'b0; latch_m = 3'b111; last_exp = 16'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_vdata", {16'd0, vdata}, 32'd0);
    check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check("rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
    check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_sram_addr", {15'd0, sram_addr}, 32'd0);

    // First fetch after reset release
    set_vram(14'h1029, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_vpix_addr", {15'd0, sram_addr}, 32'h09029);
    check("first_vpix_oe_n", {31'd0, sram_oe_n}, 32'd0);
    repeat (2) @(negedge clk);
    check("first_vcol_addr", {15'd0, sram_addr}, 32'h19029);
    @(negedge clk);
    check("vdata_before_clk5", {16'd0, vdata}, 32'd0);
    @(negedge clk);
    check("vdata_at_clk5", {16'd0, vdata}, {16'd0, exp_vdata(14'h1029)});
    repeat (2) @(negedge clk);

    // Screen write with colour latch 3'b010
    pulse_col(8'h02);
    base_we = we_cnt;
    start_cpu(1'b1, 16'h9123, 8'hA5, 1'b1);
    wait_ack(ack_n);
    check("strobes_9123", we_cnt - base_we, 32'd2);
    @(negedge clk);

    // Non-screen write: one strobe, ack after ACC_CYC access clocks plus the IDLE decision
    base_we = we_cnt;
    start_cpu(1'b1, 16'h4000, 8'h3C, 1'b1);
    wait_ack(ack_n);
    check("ack_latency_4000", ack_n, ACC + 1);
    check("strobes_4000", we_cnt - base_we, 32'd1);
    @(negedge clk);
    start_cpu(1'b0, 16'h9123, 8'h00, 1'b1);
    wait_ack(ack_n);
    @(negedge clk);

    // vram change in the same clock a screen write starts: worst-case video latency
    va = pick_vram(16'hFFFF);
    set_vram(va, 1'b1);
    start_cpu(1'b1, 16'h9456, 8'h77, 1'b1);
    fork
      wait_ack(ack_n);
      wait_vid(vid_n);
    join
    check("worst_video_latency_le9", {31'd0, vid_n <= 4 * ACC + 1}, 32'd1);
    @(negedge clk);

    // vram change during VCOL: aborted fetch never reaches vdata
    va = pick_vram(16'hFFFF);
    set_vram(va, 1'b0);
    repeat (4) @(negedge clk);
    vb = pick_vram(exp_vdata(va));
    set_vram(vb, 1'b1);
    wait_vid(vid_n);
    check("vdata_after_abort", {16'd0, vdata}, {16'd0, exp_vdata(vb)});
    @(negedge clk);

    // col_wr during the CWCOL last cycle: colour plane gets the old latch
    start_cpu(1'b1, 16'hA000, 8'h11, 1'b1);
    repeat (4) @(negedge clk);
    col_wr = 1'b1; cpu_din = 8'h05;
    wait_ack(ack_n);
    col_wr = 1'b0;
    latch_m = 3'b101;
    @(negedge clk);
    start_cpu(1'b1, 16'hB001, 8'h22, 1'b1);
    wait_ack(ack_n);
    @(negedge clk);

    // Reset during the CWR last cycle
    if (exp_vdata(14'h1029) != last_exp) begin
      set_vram(14'h1029, 1'b1);
      wait_vid(vid_n);
    end else vram = 14'h1029;
    repeat (2) @(negedge clk);
    start_cpu(1'b1, 16'h4100, 8'hEE, 1'b0);
    repeat (2) @(negedge clk);
    check("we_low_in_cwr_last", {31'd0, sram_we_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we_n_async", {31'd0, sram_we_n}, 32'd1);
    check("abort_no_ack", {31'd0, cpu_ack}, 32'd0);
    check("abort_vdata_zero", {16'd0, vdata}, 32'd0);
    check("abort_sram_addr", {15'd0, sram_addr}, 32'd0);
    cpu_req = 1'b0;
    latch_m = 3'b111;
    last_exp = 16'd0;
    set_vram(14'h1029, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_vid(vid_n);
    check("refetch_latency_after_reset", vid_n, 5);

    // Randomized mix of reads, writes, latch loads and vram moves
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        start_cpu(1'b0, 16'($urandom), 8'h00, 1'b1);
        wait_ack(ack_n);
      end else if (r <= 6) begin
        start_cpu(1'b1, pick_wr_addr(), 8'($urandom), 1'b1);
        wait_ack(ack_n);
      end else if (r == 7) begin
        pulse_col(8'($urandom));
      end else begin
        set_vram(pick_vram(16'hFFFF), 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1) start_cpu(1'b1, pick_wr_addr(), 8'($urandom), 1'b1);
          else start_cpu(1'b0, 16'($urandom), 8'h00, 1'b1);
          fork
            wait_ack(ack_n);
            wait_vid(vid_n);
          join
        end else wait_vid(vid_n);
      end
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("cpu_queue_drained", cpu_q.size(), 32'd0);
    check("video_queue_drained", vid_q.size(), 32'd0);
    check("ack_count", ack_cnt, exp_acks);
    check("write_strobe_count", we_cnt, exp_we);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
